ram8_bank: RTL and testbench



---
 rtl/ram8_bank_pkg.sv | 12 +
 rtl/ram8_bank_reg.sv | 38 +++
 rtl/ram8_bank.sv | 77 +++++++
 tb/tb_ram8_bank.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ram8_bank_pkg.sv
// Shared Hack platform widths for the ram8 bank and its neighbours.
// No logic; constants only.
// Imported by the register, bank, cpu, pc and larger ram blocks.
package ram8_bank_pkg;

    // Hack machine word width in bits.
    localparam int HACK_WORD_W = 16;

    // Address width of one 8-word bank.
    localparam int RAM8_ADDR_W = 3;

endpackage

// File: rtl/ram8_bank_reg.sv
// One storage word: WIDTH-bit register with load enable and synchronous clear.
// Latency: written value visible on out_dat the cycle after the load edge.
// Backpressure: none; accepts a load every cycle.
module ram8_bank_reg
    import ram8_bank_pkg::*;
#(
    parameter int WIDTH = HACK_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in_dat,
    output logic [WIDTH-1:0] out_dat
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value: take the new word on load, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = in_dat;
        end
    end

    // Storage flop; reset wins over any load in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out_dat = data_q;

endmodule

// File: rtl/ram8_bank.sv
// Hack RAM8: 2**ADDR_W words with one-hot write decode and combinational read select.
// Latency: read is zero-cycle on address; a write shows on out the cycle after the edge.
// Backpressure: none; a write is accepted every cycle, wrote/busy_addr report it a cycle later.
module ram8_bank
    import ram8_bank_pkg::*;
#(
    parameter int WIDTH  = HACK_WORD_W,
    parameter int ADDR_W = RAM8_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out,
    output logic [ADDR_W-1:0] busy_addr,
    output logic              wrote
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] wr_en;
    logic [WIDTH-1:0] word_dat [DEPTH];

    logic              wrote_q;
    logic              wrote_d;
    logic [ADDR_W-1:0] busy_addr_q;
    logic [ADDR_W-1:0] busy_addr_d;

    // Write demux: at most one word enabled, and only while load is high.
    always_comb begin
        wr_en = '0;
        if (load) begin
            wr_en[address] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        ram8_bank_reg #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk     (clk),
            .reset   (reset),
            .load    (wr_en[i]),
            .in_dat  (in),
            .out_dat (word_dat[i])
        );
    end

    // Read select shows the stored word, so a same-cycle write is not bypassed.
    assign out = word_dat[address];

    // Write report: pulse on every committed write, remember where it landed.
    always_comb begin
        wrote_d     = 1'b0;
        busy_addr_d = busy_addr_q;
        if (load) begin
            wrote_d     = 1'b1;
            busy_addr_d = address;
        end
    end

    // Report flops; a write in a reset cycle never commits, so nothing is reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrote_q     <= 1'b0;
            busy_addr_q <= '0;
        end else begin
            wrote_q     <= wrote_d;
            busy_addr_q <= busy_addr_d;
        end
    end

    assign wrote     = wrote_q;
    assign busy_addr = busy_addr_q;

endmodule

// File: tb/tb_ram8_bank.sv
// Directed self-checking bench for ram8_bank.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
// All expected values are hand-computed constants.
module tb_ram8_bank;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;
    logic [2:0]  busy_addr;
    logic        wrote;

    int n_checks = 0;
    int n_errors = 0;

    ram8_bank #(
        .WIDTH  (16),
        .ADDR_W (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .load      (load),
        .address   (address),
        .out       (out),
        .busy_addr (busy_addr),
        .wrote     (wrote)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Set the read address and check the combinational output.
    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        address = a;
        #1;
        chk(tag, out, exp);
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        in      = 16'h0000;
        address = 3'd0;

        // Reset, then sweep all addresses with load low.
        step();
        reset = 1'b0;
        chk("rst_wrote", {15'd0, wrote}, 16'd0);
        chk("rst_busy", {13'd0, busy_addr}, 16'd0);
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, $sformatf("rst_out%0d", a));
        step();
        chk("idle_wrote", {15'd0, wrote}, 16'd0);

        // Write 0x1000+i to each address i, watch wrote/busy_addr follow.
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            in      = 16'h1000 + 16'(i);
            load    = 1'b1;
            step();
            chk($sformatf("wr_wrote%0d", i), {15'd0, wrote}, 16'd1);
            chk($sformatf("wr_busy%0d", i), {13'd0, busy_addr}, 16'(i));
        end
        load = 1'b0;
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h1000 + 16'(a), $sformatf("rb_out%0d", a));
        step();
        chk("rb_wrote_low", {15'd0, wrote}, 16'd0);
        chk("rb_busy_hold", {13'd0, busy_addr}, 16'd7);

        // Read-during-write: old contents visible in the write cycle, new after.
        address = 3'd3; in = 16'h00AA; load = 1'b1;
        step();
        address = 3'd3; in = 16'h5555; load = 1'b1;
        #1;
        chk("rdw_old", out, 16'h00AA);
        step();
        load = 1'b0;
        #1;
        chk("rdw_new", out, 16'h5555);

        // Isolation: only word 5 changes.
        address = 3'd5; in = 16'hFFFF; load = 1'b1;
        step();
        load = 1'b0;
        rd(3'd5, 16'hFFFF, "iso_out5");
        rd(3'd4, 16'h1004, "iso_out4");
        rd(3'd6, 16'h1006, "iso_out6");
        rd(3'd3, 16'h5555, "iso_out3");
        rd(3'd0, 16'h1000, "iso_out0");
        chk("iso_busy", {13'd0, busy_addr}, 16'd5);

        // Back-to-back writes to address 7: last wins, wrote stays high.
        address = 3'd7; in = 16'h0001; load = 1'b1;
        step();
        chk("b2b_wrote1", {15'd0, wrote}, 16'd1);
        chk("b2b_busy1", {13'd0, busy_addr}, 16'd7);
        in = 16'h0002;
        #1;
        chk("b2b_mid_out", out, 16'h0001);
        step();
        load = 1'b0;
        chk("b2b_wrote2", {15'd0, wrote}, 16'd1);
        chk("b2b_busy2", {13'd0, busy_addr}, 16'd7);
        rd(3'd7, 16'h0002, "b2b_out7");
        step();
        chk("b2b_wrote_low", {15'd0, wrote}, 16'd0);
        chk("b2b_busy_hold", {13'd0, busy_addr}, 16'd7);

        // Reset priority: concurrent write discarded, everything cleared.
        reset = 1'b1; load = 1'b1; address = 3'd2; in = 16'hBEEF;
        step();
        reset = 1'b0; load = 1'b0;
        chk("rp_wrote", {15'd0, wrote}, 16'd0);
        chk("rp_busy", {13'd0, busy_addr}, 16'd0);
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, $sformatf("rp_out%0d", a));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Bound the run in case the flow above stalls.
    initial begin
        #20000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
